mips_reg_dump: RTL and testbench

//  Hardware read-out engine for the MIPS32 register file. It detects the

---
 rtl/mips_reg_dump_pkg.sv | 13 +
 rtl/mips_reg_dump_if.sv | 16 +
 rtl/mips_reg_dump.sv | 92 +++++++++
 tb/tb_mips_reg_dump.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_reg_dump_pkg.sv
// Shared definitions for the MIPS register dump engine: FSM encoding and
// default register-file geometry.
package mips_dbg_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
endpackage

// File: rtl/mips_reg_dump_if.sv
// Valid/ready stream carrying one (index, value) register word per transfer.
interface mips_reg_dump_if
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_W
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (output dump_valid, dump_idx, dump_data, dump_last, input dump_ready);
  modport slave  (input dump_valid, dump_idx, dump_data, dump_last, output dump_ready);
endinterface

// File: rtl/mips_reg_dump.sv
// Register-file read-out engine: on a HALTED rising edge, scans R0..NUM_REGS-1
// and streams each (index, value) word over a valid/ready port.
module mips_reg_dump
  import mips_dbg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = WORD_W
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                halted,
  output logic [ADDR_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]   rf_rdata,
  mips_reg_dump_if.master     dump,
  output logic                busy,
  output logic                done
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic              halted_q;
  logic              armed_q;
  logic              valid_q, last_q;
  logic [ADDR_W-1:0] oidx_q;
  logic [DATA_W-1:0] data_q;
  logic              start, xfer;

  // armed_q blocks a dump when reset is released with halted already high:
  // halted must be seen low at least once before a rising edge counts.
  assign start = halted & ~halted_q & armed_q;
  assign xfer  = valid_q & dump.dump_ready;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted;
      armed_q  <= armed_q | ~halted;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = SEND;
      SEND:    if (xfer) state_d = last_q ? DONE : READ;
      DONE:    if (!halted) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (state_q == IDLE && start) begin
      idx_q <= '0;
    end else if (state_q == SEND && xfer && !last_q) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Output word is captured in READ and frozen until the sink takes it.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      oidx_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (state_q == READ) begin
      valid_q <= 1'b1;
      oidx_q  <= idx_q;
      data_q  <= rf_rdata;
      last_q  <= (idx_q == LAST_IDX);
    end else if (state_q == SEND && xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign rf_raddr        = (state_q == READ) ? idx_q : '0;
  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = oidx_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;
  assign busy            = (state_q == READ) | (state_q == SEND);
  assign done            = (state_q == DONE);
endmodule

// File: tb/tb_mips_reg_dump.sv
// Randomized bench for mips_reg_dump: a word-queue scoreboard built from the
// register-file image checks every transfer, hold stability and done timing.
module tb_mips_reg_dump;
  import mips_dbg_pkg::*;
  localparam int N = 32;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy, done;
  logic [31:0] rf [N];

  mips_reg_dump_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  mips_reg_dump #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump(dif.master), .busy(busy), .done(done)
  );

  assign rf_rdata = rf[rf_raddr];

  always #5 clk1 = ~clk1;

  int checks = 0, errors = 0, cyc = 0;
  int n_acc = 0, done_cyc = 0, start_cyc = 0, mode = 0;
  int exp_idx[$];
  logic [31:0] exp_data[$];
  logic [31:0] log_data[1024];
  int log_idx[1024];
  logic pv = 0, pacc = 0, plast = 0, prev_done = 0;
  logic [4:0] pidx = '0;
  logic [31:0] pdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk1);
    cyc++;
  end

  // Sink ready: 0 = always ready, 1 = 3-cycle stall per word, 2 = random.
  initial begin
    int stall;
    stall = 0;
    dif.dump_ready = 1'b1;
    forever begin
      @(posedge clk1);
      #1;
      case (mode)
        1: begin
          if (dif.dump_valid && stall < 3) begin
            dif.dump_ready = 1'b0;
            stall++;
          end else begin
            dif.dump_ready = 1'b1;
            if (dif.dump_valid) stall = 0;
          end
        end
        2: dif.dump_ready = 1'($urandom_range(0, 1));
        default: dif.dump_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every transfer against the expected word queue.
  initial forever begin
    @(negedge clk1);
    if (!rst_n) begin
      exp_idx.delete();
      exp_data.delete();
      pv = 0; pacc = 0; plast = 0; prev_done = 0;
    end else begin
      if (pv && !pacc) begin
        chk("hold_valid", 64'(dif.dump_valid), 64'd1);
        chk("hold_idx", 64'(dif.dump_idx), 64'(pidx));
        chk("hold_data", 64'(dif.dump_data), 64'(pdata));
        chk("hold_last", 64'(dif.dump_last), 64'(plast));
      end
      if (pacc && plast) chk("done_after_last", 64'(done), 64'd1);
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
      if (dif.dump_valid && dif.dump_ready) begin
        if (exp_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d, want no word", dif.dump_idx);
        end else begin
          int ei;
          logic [31:0] ed;
          ei = exp_idx.pop_front();
          ed = exp_data.pop_front();
          chk("word_idx", 64'(dif.dump_idx), 64'(ei));
          chk("word_data", 64'(dif.dump_data), 64'(ed));
          chk("word_last", 64'(dif.dump_last), 64'(ei == N - 1));
        end
        log_data[n_acc % 1024] = dif.dump_data;
        log_idx[n_acc % 1024]  = int'(dif.dump_idx);
        n_acc++;
      end
      pv = dif.dump_valid;
      pidx = dif.dump_idx;
      pdata = dif.dump_data;
      plast = dif.dump_last;
      pacc = dif.dump_valid & dif.dump_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Called just after a posedge; the following posedge is the start edge.
  task automatic start_dump();
    for (int i = 0; i < N; i++) begin
      exp_idx.push_back(i);
      exp_data.push_back(rf[i]);
    end
    halted = 1'b1;
    start_cyc = cyc + 1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_acc < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(n_acc >= target), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(dif.dump_valid), 64'd0);
    chk({tag, "_idx"}, 64'(dif.dump_idx), 64'd0);
    chk({tag, "_data"}, 64'(dif.dump_data), 64'd0);
    chk({tag, "_last"}, 64'(dif.dump_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_raddr"}, 64'(rf_raddr), 64'd0);
  endtask

  initial begin
    int base;
    logic [31:0] lit [6];
    lit[0] = 32'd0; lit[1] = 32'd10; lit[2] = 32'd20;
    lit[3] = 32'd25; lit[4] = 32'd30; lit[5] = 32'd55;
    for (int i = 0; i < N; i++) rf[i] = (i < 6) ? lit[i] : 32'd0;

    tick();
    tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // Test 1: fixed image, ready high, done latency.
    base = n_acc;
    start_dump();
    wait_done(200, "t1_done_reached");
    tick();
    chk("t1_count", 64'(n_acc - base), 64'd32);
    for (int i = 0; i < 6; i++) chk("t1_literal_data", 64'(log_data[base + i]), 64'(lit[i]));
    chk("t1_literal_idx31", 64'(log_idx[base + 31]), 64'd31);
    chk("t1_done_latency", 64'(done_cyc - start_cyc), 64'd64);

    // Test 3: done holds while halted, clears one edge after the fall.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_done_held", 64'(done), 64'd1);
    end
    halted = 1'b0;
    tick();
    chk("t3_done_cleared", 64'(done), 64'd0);
    base = n_acc;
    repeat (20) tick();
    chk("t3_no_redump_busy", 64'(busy), 64'd0);
    chk("t3_no_redump_words", 64'(n_acc - base), 64'd0);

    // Test 2: backpressure, 3 stall cycles on every word.
    for (int i = 0; i < N; i++) rf[i] = $urandom;
    mode = 1;
    base = n_acc;
    start_dump();
    wait_done(600, "t2_done_reached");
    chk("t2_count", 64'(n_acc - base), 64'd32);
    halted = 1'b0;
    tick();
    tick();

    // Test 4: halted falls after word 5, rises again at word 10.
    for (int i = 0; i < N; i++) rf[i] = $urandom;
    mode = 2;
    base = n_acc;
    start_dump();
    wait_acc(base + 5, 200, "t4_reach_word5");
    halted = 1'b0;
    wait_acc(base + 10, 200, "t4_reach_word10");
    halted = 1'b1;
    wait_done(600, "t4_done_reached");
    chk("t4_count", 64'(n_acc - base), 64'd32);
    repeat (3) begin
      tick();
      chk("t4_done_held", 64'(done), 64'd1);
    end
    halted = 1'b0;
    tick();
    tick();
    chk("t4_idle_busy", 64'(busy), 64'd0);
    chk("t4_no_restart", 64'(n_acc - base), 64'd32);

    // Test 5: async reset during SEND of idx 7.
    mode = 0;
    start_dump();
    begin
      int k;
      k = 0;
      while (!(dif.dump_valid && dif.dump_idx == 5'd7) && k < 100) begin
        tick();
        k++;
      end
      chk("t5_reach_idx7", 64'(dif.dump_valid && dif.dump_idx == 5'd7), 64'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5_async");
    tick();
    tick();
    rst_n = 1'b1;
    base = n_acc;
    repeat (20) tick();
    chk("t5_no_dump_busy", 64'(busy), 64'd0);
    chk("t5_no_dump_words", 64'(n_acc - base), 64'd0);
    halted = 1'b0;
    tick();
    tick();
    base = n_acc;
    start_dump();
    wait_done(200, "t5_done_reached");
    chk("t5_count", 64'(n_acc - base), 64'd32);
    chk("t5_first_idx", 64'(log_idx[base]), 64'd0);
    halted = 1'b0;
    tick();
    tick();

    // Test 6: random data, ready high, strict 1,0,1,0 valid pattern.
    for (int i = 0; i < N; i++) rf[i] = $urandom;
    base = n_acc;
    start_dump();
    tick();
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("t6_valid_pattern", 64'(dif.dump_valid), 64'(i % 2 == 0));
    end
    wait_done(10, "t6_done_reached");
    chk("t6_count", 64'(n_acc - base), 64'd32);
    halted = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
